// File: rtl/eth_tx_src_arb.sv
// eth_tx_src_arb: per-channel store-and-forward packet FIFOs feeding one
// SOP/EOP-framed byte stream through a round-robin / fixed-priority arbiter.
module eth_tx_src_arb #(
  parameter int unsigned pNum_Ch     = 3,
  parameter int unsigned pFifo_Depth = 64,
  parameter int unsigned pGap_Cycles = 2
) (
  input  logic                       Clk,
  input  logic                       Rstn,
  input  logic [pNum_Ch*10-1:0]      Ch_Byte,
  input  logic [pNum_Ch-1:0]         Ch_Byte_Valid,
  input  logic [pNum_Ch-1:0]         Ch_En,
  input  logic                       Arb_Mode,
  output logic [9:0]                 Eth_Byte_Tx,
  output logic                       Eth_Byte_Valid_Tx,
  output logic [$clog2(pNum_Ch)-1:0] Grant_Ch,
  output logic                       Busy,
  output logic [pNum_Ch-1:0]         Drop_Pulse
);

  localparam int unsigned AW = $clog2(pFifo_Depth);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(pNum_Ch);
  localparam int unsigned GW = (pGap_Cycles > 1) ? $clog2(pGap_Cycles) : 1;

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DISCARD} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_SEND, R_GAP} rd_state_e;

  logic [9:0]    mem [pNum_Ch][pFifo_Depth];
  wr_state_e     wst_q [pNum_Ch];
  wr_state_e     wst_d [pNum_Ch];
  logic [PW-1:0] wp_q  [pNum_Ch];
  logic [PW-1:0] wp_d  [pNum_Ch];
  logic [PW-1:0] sp_q  [pNum_Ch];
  logic [PW-1:0] sp_d  [pNum_Ch];
  logic [PW-1:0] rp_q  [pNum_Ch];
  logic [PW-1:0] cnt_q [pNum_Ch];
  logic [AW-1:0] wa    [pNum_Ch];
  logic [pNum_Ch-1:0] full, we, commit, drop, rd_inc, rd_dec;

  rd_state_e     rd_state;
  logic [GW-1:0] gap_cnt;
  logic          arb_found, can_arb, launch, cont, rd_fire;
  logic [CW-1:0] arb_ch, rd_ch;
  logic [9:0]    rd_byte;

  // Occupancy counts uncommitted bytes too; reads never pass a packet start.
  always_comb begin
    for (int i = 0; i < int'(pNum_Ch); i++)
      full[i] = (PW'(wp_q[i] - rp_q[i]) == PW'(pFifo_Depth));
  end

  // Write-side framing: start, commit, abort and discard decisions per channel.
  always_comb begin
    for (int i = 0; i < int'(pNum_Ch); i++) begin
      wst_d[i]  = wst_q[i];
      wp_d[i]   = wp_q[i];
      sp_d[i]   = sp_q[i];
      wa[i]     = wp_q[i][AW-1:0];
      we[i]     = 1'b0;
      commit[i] = 1'b0;
      drop[i]   = 1'b0;
      if (!Ch_En[i]) begin
        if (wst_q[i] == W_PKT) begin
          wp_d[i]  = sp_q[i];
          drop[i]  = 1'b1;
          wst_d[i] = W_IDLE;
        end
      end else if (Ch_Byte_Valid[i]) begin
        case (wst_q[i])
          W_PKT: begin
            if (Ch_Byte[10*i+9]) begin
              // restart: the aborted packet always frees room for this byte
              wa[i]   = sp_q[i][AW-1:0];
              we[i]   = 1'b1;
              wp_d[i] = sp_q[i] + PW'(1);
              drop[i] = 1'b1;
              if (Ch_Byte[10*i+8]) begin
                commit[i] = 1'b1;
                wst_d[i]  = W_IDLE;
              end
            end else if (full[i]) begin
              wp_d[i]  = sp_q[i];
              drop[i]  = 1'b1;
              wst_d[i] = Ch_Byte[10*i+8] ? W_IDLE : W_DISCARD;
            end else begin
              we[i]   = 1'b1;
              wp_d[i] = wp_q[i] + PW'(1);
              if (Ch_Byte[10*i+8]) begin
                commit[i] = 1'b1;
                wst_d[i]  = W_IDLE;
              end
            end
          end
          default: begin
            if (Ch_Byte[10*i+9]) begin
              if (full[i]) begin
                drop[i]  = 1'b1;
                wst_d[i] = Ch_Byte[10*i+8] ? W_IDLE : W_DISCARD;
              end else begin
                we[i]   = 1'b1;
                sp_d[i] = wp_q[i];
                wp_d[i] = wp_q[i] + PW'(1);
                if (Ch_Byte[10*i+8]) begin
                  commit[i] = 1'b1;
                  wst_d[i]  = W_IDLE;
                end else begin
                  wst_d[i] = W_PKT;
                end
              end
            end else if (wst_q[i] == W_IDLE) begin
              drop[i] = 1'b1;
            end else if (Ch_Byte[10*i+8]) begin
              wst_d[i] = W_IDLE;
            end
          end
        endcase
      end
    end
  end

  // Write-side state registers and drop pulses.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      for (int i = 0; i < int'(pNum_Ch); i++) begin
        wst_q[i] <= W_IDLE;
        wp_q[i]  <= '0;
        sp_q[i]  <= '0;
      end
      Drop_Pulse <= '0;
    end else begin
      for (int i = 0; i < int'(pNum_Ch); i++) begin
        wst_q[i] <= wst_d[i];
        wp_q[i]  <= wp_d[i];
        sp_q[i]  <= sp_d[i];
      end
      Drop_Pulse <= drop;
    end
  end

  // Packet storage; contents are don't-care until pointers cover them.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < int'(pNum_Ch); i++)
      if (we[i]) mem[i][wa[i]] <= Ch_Byte[10*i +: 10];
  end

  // Arbitration: lowest pending index, or first pending after last grant.
  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    if (Arb_Mode) begin
      for (int i = int'(pNum_Ch) - 1; i >= 0; i--)
        if (cnt_q[i] != '0) begin
          arb_found = 1'b1;
          arb_ch    = CW'(i);
        end
    end else begin
      for (int k = int'(pNum_Ch); k >= 1; k--)
        if (cnt_q[(int'(Grant_Ch) + k) % int'(pNum_Ch)] != '0) begin
          arb_found = 1'b1;
          arb_ch    = CW'((int'(Grant_Ch) + k) % int'(pNum_Ch));
        end
    end
  end

  // Read pointer selection; the last gap cycle can launch the next packet.
  always_comb begin
    can_arb = (rd_state == R_IDLE) ||
              ((rd_state == R_GAP) && (gap_cnt == GW'(pGap_Cycles - 1)));
    launch  = can_arb && arb_found;
    cont    = (rd_state == R_SEND) && !Eth_Byte_Tx[8];
    rd_fire = launch || cont;
    rd_ch   = launch ? arb_ch : Grant_Ch;
    rd_byte = mem[rd_ch][rp_q[rd_ch][AW-1:0]];
    for (int i = 0; i < int'(pNum_Ch); i++) begin
      rd_inc[i] = rd_fire && (rd_ch == CW'(i));
      rd_dec[i] = rd_inc[i] && rd_byte[8];
    end
  end

  // Read pointers and committed packet counts.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      for (int i = 0; i < int'(pNum_Ch); i++) begin
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(pNum_Ch); i++) begin
        rp_q[i]  <= rp_q[i] + PW'(rd_inc[i]);
        cnt_q[i] <= cnt_q[i] + PW'(commit[i]) - PW'(rd_dec[i]);
      end
    end
  end

  // Output FSM: replay one packet without bubbles, then hold the gap.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      rd_state          <= R_IDLE;
      gap_cnt           <= '0;
      Eth_Byte_Tx       <= '0;
      Eth_Byte_Valid_Tx <= 1'b0;
      Grant_Ch          <= CW'(pNum_Ch - 1);
      Busy              <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (launch) begin
            Eth_Byte_Tx       <= rd_byte;
            Eth_Byte_Valid_Tx <= 1'b1;
            Grant_Ch          <= arb_ch;
            Busy              <= 1'b1;
            rd_state          <= R_SEND;
          end else begin
            Eth_Byte_Valid_Tx <= 1'b0;
          end
        end
        R_SEND: begin
          if (Eth_Byte_Tx[8]) begin
            Eth_Byte_Valid_Tx <= 1'b0;
            gap_cnt           <= '0;
            rd_state          <= R_GAP;
          end else begin
            Eth_Byte_Tx       <= rd_byte;
            Eth_Byte_Valid_Tx <= 1'b1;
          end
        end
        R_GAP: begin
          if (gap_cnt == GW'(pGap_Cycles - 1)) begin
            if (launch) begin
              Eth_Byte_Tx       <= rd_byte;
              Eth_Byte_Valid_Tx <= 1'b1;
              Grant_Ch          <= arb_ch;
              rd_state          <= R_SEND;
            end else begin
              Busy     <= 1'b0;
              rd_state <= R_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_src_arb.sv
// Directed bench for eth_tx_src_arb (3 channels, 64-byte FIFOs, 2-cycle gap).
module tb_eth_tx_src_arb;

  logic        Clk = 1'b0;
  logic        Rstn;
  logic [29:0] Ch_Byte;
  logic [2:0]  Ch_Byte_Valid;
  logic [2:0]  Ch_En;
  logic        Arb_Mode;
  logic [9:0]  Eth_Byte_Tx;
  logic        Eth_Byte_Valid_Tx;
  logic [1:0]  Grant_Ch;
  logic        Busy;
  logic [2:0]  Drop_Pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [9:0] ob[$];
  int         oc[$];
  logic [1:0] og[$];
  int         drop_cnt [3];
  int         drop_cyc [3];

  eth_tx_src_arb #(.pNum_Ch(3), .pFifo_Depth(64), .pGap_Cycles(2)) dut (
    .Clk(Clk), .Rstn(Rstn), .Ch_Byte(Ch_Byte), .Ch_Byte_Valid(Ch_Byte_Valid),
    .Ch_En(Ch_En), .Arb_Mode(Arb_Mode), .Eth_Byte_Tx(Eth_Byte_Tx),
    .Eth_Byte_Valid_Tx(Eth_Byte_Valid_Tx), .Grant_Ch(Grant_Ch), .Busy(Busy),
    .Drop_Pulse(Drop_Pulse)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Record every output byte with the cycle it was seen and the grant.
  always @(negedge Clk) begin
    if (Rstn === 1'b1 && Eth_Byte_Valid_Tx === 1'b1) begin
      ob.push_back(Eth_Byte_Tx);
      oc.push_back(cyc);
      og.push_back(Grant_Ch);
    end
    if (Rstn === 1'b1)
      for (int c = 0; c < 3; c++)
        if (Drop_Pulse[c] === 1'b1) begin
          drop_cnt[c]++;
          drop_cyc[c] = cyc;
        end
  end

  function automatic logic [9:0] exp_byte(input int c, input int k, input int len, input int base);
    logic [7:0] d;
    d = 8'(base + c*16 + k);
    return {(k == 0), (k == len - 1), d};
  endfunction

  task automatic clear_log();
    ob.delete(); oc.delete(); og.delete();
    for (int c = 0; c < 3; c++) begin
      drop_cnt[c] = 0;
      drop_cyc[c] = -1;
    end
  endtask

  // Drive len-byte packets on every channel in mask, one byte per cycle.
  task automatic send_multi(input logic [2:0] mask, input int len, input int base, output int start);
    start = 0;
    for (int k = 0; k < len; k++) begin
      @(posedge Clk); #1;
      if (k == 0) start = cyc;
      for (int c = 0; c < 3; c++) Ch_Byte[10*c +: 10] = exp_byte(c, k, len, base);
      Ch_Byte_Valid = mask;
    end
  endtask

  task automatic drive_one(input int ch, input logic [9:0] b);
    @(posedge Clk); #1;
    Ch_Byte[10*ch +: 10] = b;
    Ch_Byte_Valid = 3'b000;
    Ch_Byte_Valid[ch] = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge Clk); #1;
      Ch_Byte_Valid = 3'b000;
    end
  endtask

  task automatic test_reset();
    Rstn = 1'b0; Ch_Byte = '0; Ch_Byte_Valid = '0; Ch_En = 3'b111; Arb_Mode = 1'b0;
    clear_log();
    repeat (3) @(posedge Clk);
    #1 Rstn = 1'b1;
    @(negedge Clk);
    n_checks++; if (Eth_Byte_Valid_Tx !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", Eth_Byte_Valid_Tx); end
    n_checks++; if (Eth_Byte_Tx !== 10'h000) begin n_fail++; $display("FAIL reset_byte got %h want 000", Eth_Byte_Tx); end
    n_checks++; if (Grant_Ch !== 2'd2) begin n_fail++; $display("FAIL reset_grant got %0d want 2", Grant_Ch); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", Busy); end
    n_checks++; if (Drop_Pulse !== 3'b000) begin n_fail++; $display("FAIL reset_drop got %b want 000", Drop_Pulse); end
  endtask

  task automatic test_single();
    int st, t;
    logic exp_busy;
    clear_log();
    send_multi(3'b001, 5, 1, st);
    t = st + 4;
    idle_cycles(1);
    repeat (12) begin
      @(negedge Clk);
      exp_busy = (cyc >= t + 2) && (cyc <= t + 8);
      n_checks++;
      if (Busy !== exp_busy) begin n_fail++; $display("FAIL single_busy cyc=%0d got %b want %b", cyc - t, Busy, exp_busy); end
    end
    n_checks++; if (ob.size() !== 5) begin n_fail++; $display("FAIL single_count got %0d want 5", ob.size()); end
    for (int k = 0; k < 5; k++)
      if (k < ob.size()) begin
        n_checks++;
        if ({ob[k], oc[k] - t, og[k]} !== {exp_byte(0, k, 5, 1), 32'(2 + k), 2'd0}) begin
          n_fail++;
          $display("FAIL single_byte%0d got %h@t+%0d g%0d want %h@t+%0d g0", k, ob[k], oc[k] - t, og[k], exp_byte(0, k, 5, 1), 2 + k);
        end
      end
  endtask

  task automatic test_round_robin();
    int st, t;
    int order[3];
    clear_log();
    test_reset();
    send_multi(3'b111, 4, 0, st);
    t = st + 3;
    idle_cycles(1);
    repeat (24) @(negedge Clk);
    n_checks++; if (ob.size() !== 12) begin n_fail++; $display("FAIL rr3_count got %0d want 12", ob.size()); end
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 4; k++)
        if (p*4 + k < ob.size()) begin
          n_checks++;
          if ({ob[p*4+k], oc[p*4+k] - t, og[p*4+k]} !== {exp_byte(p, k, 4, 0), 32'(2 + p*6 + k), 2'(p)}) begin
            n_fail++;
            $display("FAIL rr3_p%0d_b%0d got %h@t+%0d g%0d want %h@t+%0d g%0d", p, k, ob[p*4+k], oc[p*4+k] - t, og[p*4+k], exp_byte(p, k, 4, 0), 2 + p*6 + k, p);
          end
        end
    clear_log();
    order = '{1, 2, 0};
    send_multi(3'b110, 4, 8, st);
    t = st + 3;
    idle_cycles(1);
    repeat (20) @(negedge Clk);
    n_checks++; if (ob.size() !== 8) begin n_fail++; $display("FAIL rr2_count got %0d want 8", ob.size()); end
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 4; k++)
        if (p*4 + k < ob.size()) begin
          n_checks++;
          if ({ob[p*4+k], oc[p*4+k] - t, og[p*4+k]} !== {exp_byte(order[p], k, 4, 8), 32'(2 + p*6 + k), 2'(order[p])}) begin
            n_fail++;
            $display("FAIL rr2_p%0d_b%0d got %h@t+%0d g%0d want %h@t+%0d", p, k, ob[p*4+k], oc[p*4+k] - t, og[p*4+k], exp_byte(order[p], k, 4, 8), 2 + p*6 + k);
          end
        end
  endtask

  task automatic test_fixed_priority();
    int st, t, st0;
    clear_log();
    Arb_Mode = 1'b1;
    send_multi(3'b100, 6, 3, st);
    t = st + 5;
    send_multi(3'b001, 3, 6, st0);
    idle_cycles(1);
    repeat (16) @(negedge Clk);
    n_checks++; if (ob.size() !== 9) begin n_fail++; $display("FAIL fix_count got %0d want 9", ob.size()); end
    for (int k = 0; k < 9; k++)
      if (k < ob.size()) begin
        n_checks++;
        if (k < 6) begin
          if ({ob[k], oc[k] - t, og[k]} !== {exp_byte(2, k, 6, 3), 32'(2 + k), 2'd2}) begin
            n_fail++; $display("FAIL fix_ch2_b%0d got %h@t+%0d g%0d want %h@t+%0d g2", k, ob[k], oc[k] - t, og[k], exp_byte(2, k, 6, 3), 2 + k);
          end
        end else if ({ob[k], oc[k] - t, og[k]} !== {exp_byte(0, k - 6, 3, 6), 32'(4 + k), 2'd0}) begin
          n_fail++; $display("FAIL fix_ch0_b%0d got %h@t+%0d g%0d want %h@t+%0d g0", k - 6, ob[k], oc[k] - t, og[k], exp_byte(0, k - 6, 3, 6), 4 + k);
        end
      end
    clear_log();
    send_multi(3'b101, 3, 9, st);
    t = st + 2;
    idle_cycles(1);
    repeat (14) @(negedge Clk);
    n_checks++; if (ob.size() !== 6) begin n_fail++; $display("FAIL fix2_count got %0d want 6", ob.size()); end
    if (ob.size() == 6) begin
      n_checks++;
      if ({ob[0], oc[0] - t, og[0], ob[3], oc[3] - t, og[3]} !==
          {exp_byte(0, 0, 3, 9), 32'd2, 2'd0, exp_byte(2, 0, 3, 9), 32'd7, 2'd2}) begin
        n_fail++; $display("FAIL fix2_order got %h@t+%0d g%0d then %h@t+%0d g%0d want ch0@t+2 then ch2@t+7", ob[0], oc[0] - t, og[0], ob[3], oc[3] - t, og[3]);
      end
    end
    Arb_Mode = 1'b0;
  endtask

  task automatic test_overflow();
    int st, t;
    clear_log();
    send_multi(3'b010, 70, 0, st);
    idle_cycles(6);
    n_checks++; if (drop_cnt[1] !== 1) begin n_fail++; $display("FAIL ovf_drop_count got %0d want 1", drop_cnt[1]); end
    n_checks++; if (drop_cyc[1] - st !== 65) begin n_fail++; $display("FAIL ovf_drop_cycle got s+%0d want s+65", drop_cyc[1] - st); end
    n_checks++; if (drop_cnt[0] + drop_cnt[2] !== 0) begin n_fail++; $display("FAIL ovf_other_drops got %0d want 0", drop_cnt[0] + drop_cnt[2]); end
    n_checks++; if (ob.size() !== 0) begin n_fail++; $display("FAIL ovf_no_output got %0d bytes want 0", ob.size()); end
    send_multi(3'b010, 3, 128, st);
    t = st + 2;
    idle_cycles(1);
    repeat (10) @(negedge Clk);
    n_checks++; if (ob.size() !== 3) begin n_fail++; $display("FAIL ovf_next_count got %0d want 3", ob.size()); end
    for (int k = 0; k < 3; k++)
      if (k < ob.size()) begin
        n_checks++;
        if ({ob[k], oc[k] - t, og[k]} !== {exp_byte(1, k, 3, 128), 32'(2 + k), 2'd1}) begin
          n_fail++; $display("FAIL ovf_next_b%0d got %h@t+%0d g%0d want %h@t+%0d g1", k, ob[k], oc[k] - t, og[k], exp_byte(1, k, 3, 128), 2 + k);
        end
      end
  endtask

  task automatic test_abort();
    logic [9:0] exp_q [4];
    clear_log();
    exp_q = '{10'h260, 10'h061, 10'h062, 10'h163};
    drive_one(0, 10'h250);
    drive_one(0, 10'h051);
    drive_one(0, 10'h052);
    for (int k = 0; k < 4; k++) drive_one(0, exp_q[k]);
    idle_cycles(1);
    repeat (12) @(negedge Clk);
    n_checks++; if (drop_cnt[0] !== 1) begin n_fail++; $display("FAIL abort_drop_count got %0d want 1", drop_cnt[0]); end
    n_checks++; if (ob.size() !== 4) begin n_fail++; $display("FAIL abort_count got %0d want 4", ob.size()); end
    for (int k = 0; k < 4; k++)
      if (k < ob.size()) begin
        n_checks++;
        if (ob[k] !== exp_q[k]) begin n_fail++; $display("FAIL abort_b%0d got %h want %h", k, ob[k], exp_q[k]); end
      end
  endtask

  task automatic test_reset_mid_send();
    int st, t;
    clear_log();
    send_multi(3'b100, 20, 64, st);
    t = st + 19;
    idle_cycles(1);
    repeat (5) @(posedge Clk);
    #2;
    n_checks++; if (Eth_Byte_Valid_Tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_sending got %b want 1", Eth_Byte_Valid_Tx); end
    Rstn = 1'b0;
    #1;
    n_checks++; if (Eth_Byte_Valid_Tx !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", Eth_Byte_Valid_Tx); end
    n_checks++; if ({Busy, Grant_Ch} !== 3'b010) begin n_fail++; $display("FAIL rst_mid_busy_grant got %b want 010", {Busy, Grant_Ch}); end
    clear_log();
    repeat (2) @(posedge Clk);
    #1 Rstn = 1'b1;
    repeat (30) @(negedge Clk);
    n_checks++; if (ob.size() !== 0) begin n_fail++; $display("FAIL rst_mid_residue got %0d bytes want 0", ob.size()); end
    send_multi(3'b001, 3, 160, st);
    t = st + 2;
    idle_cycles(1);
    repeat (10) @(negedge Clk);
    n_checks++; if (ob.size() !== 3) begin n_fail++; $display("FAIL rst_after_count got %0d want 3", ob.size()); end
    for (int k = 0; k < 3; k++)
      if (k < ob.size()) begin
        n_checks++;
        if ({ob[k], oc[k] - t, og[k]} !== {exp_byte(0, k, 3, 160), 32'(2 + k), 2'd0}) begin
          n_fail++; $display("FAIL rst_after_b%0d got %h@t+%0d g%0d want %h@t+%0d g0", k, ob[k], oc[k] - t, og[k], exp_byte(0, k, 3, 160), 2 + k);
        end
      end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_overflow();
    test_abort();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
